// File: rtl/yd_pkg.sv
// Shared constants for the yd data-bus arbiter: bus widths, master indices
// and the starvation counter width.
package yd_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam int M_CORE = 0;
    localparam int M_AUX  = 1;
    localparam int CNT_W  = 4;
endpackage

// File: rtl/yd_starve_cnt.sv
// Saturating count of consecutive denied cycles for the aux master; raises
// boost once the count reaches the threshold, drops it on grant or release.
module yd_starve_cnt
    import yd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             gnt,
    input  logic [CNT_W-1:0] threshold,
    output logic             boost
);

    logic [CNT_W-1:0] cnt;
    logic             denied;

    assign denied = req & ~gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            boost <= 1'b0;
        end else if (!denied) begin
            cnt   <= '0;
            boost <= 1'b0;
        end else begin
            if (cnt != '1)
                cnt <= cnt + 1'b1;
            // This edge is the threshold-th consecutive denial.
            if (cnt == threshold - 1'b1)
                boost <= 1'b1;
        end
    end

endmodule

// File: rtl/yd_dbus_arb.sv
// Two-master arbiter for the single-port data RAM: fixed priority to the core
// with a one-shot anti-starvation boost for the aux master.
module yd_dbus_arb
    import yd_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_din,
    output logic          m0_gnt,
    output logic          m0_vld,
    output logic [DW-1:0] m0_dout,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_din,
    output logic          m1_gnt,
    output logic          m1_vld,
    output logic [DW-1:0] m1_dout,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          starve_o
);

    localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_MAX);

    logic       boost;
    logic [1:0] rd_own;

    yd_starve_cnt u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (m1_req),
        .gnt       (m1_gnt),
        .threshold (STARVE_THR),
        .boost     (boost)
    );

    always_comb begin
        m1_gnt = rst_n & m1_req & (~m0_req | boost);
        m0_gnt = rst_n & m0_req & ~m1_gnt;
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (m1_gnt) begin
            mem_addr = m1_addr;
            mem_din  = m1_din;
            mem_we   = m1_we;
        end else if (m0_gnt) begin
            mem_addr = m0_addr;
            mem_din  = m0_din;
            mem_we   = m0_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_own <= 2'b00;
        else
            rd_own <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
    end

    // Gating with rst_n kills a read that was granted just before reset.
    assign m0_vld   = rst_n & rd_own[M_CORE];
    assign m1_vld   = rst_n & rd_own[M_AUX];
    assign m0_dout  = m0_vld ? mem_dout : '0;
    assign m1_dout  = m1_vld ? mem_dout : '0;
    assign starve_o = boost;

endmodule

// File: tb/tb_yd_dbus_arb.sv
// Scoreboard bench for yd_dbus_arb: driver checks grants/mux and queues
// expected read returns; a negedge monitor pops and checks them.
module tb_yd_dbus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_din, m1_addr, m1_din;
    logic        m0_gnt, m0_vld, m1_gnt, m1_vld;
    logic [15:0] m0_dout, m1_dout;
    logic [15:0] mem_addr, mem_din, mem_dout;
    logic        mem_we, starve_o;

    int tests = 0;
    int fails = 0;

    logic [15:0] ram [0:255];
    logic [16:0] exp_q [$];

    always #5 clk = ~clk;

    yd_dbus_arb #(.AW(16), .DW(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_vld(m0_vld), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_vld(m1_vld), .m1_dout(m1_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .starve_o(starve_o)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_din;
        mem_dout <= ram[mem_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m0_vld || m1_vld) begin
            chk("vld_exclusive", {31'd0, m0_vld & m1_vld}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_vld", {30'd0, m1_vld, m0_vld}, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (e[16]) begin
                    chk("m1_vld", {31'd0, m1_vld}, 32'd1);
                    chk("m1_dout", {16'd0, m1_dout}, {16'd0, e[15:0]});
                    chk("m0_dout_quiet", {16'd0, m0_dout}, 32'd0);
                end else begin
                    chk("m0_vld", {31'd0, m0_vld}, 32'd1);
                    chk("m0_dout", {16'd0, m0_dout}, {16'd0, e[15:0]});
                    chk("m1_dout_quiet", {16'd0, m1_dout}, 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_din = d;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_din = d;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        set_m1(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Both masters read continuously from a fresh counter: aux wins every fifth cycle.
    task automatic contend(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            set_m0(1'b1, 1'b0, 16'h0001, 16'h0);
            set_m1(1'b1, 1'b0, 16'h0002, 16'h0);
            #1;
            chk($sformatf("cont_m0_gnt_%0d", i), {31'd0, m0_gnt}, {31'd0, (i % 5) != 4});
            chk($sformatf("cont_m1_gnt_%0d", i), {31'd0, m1_gnt}, {31'd0, (i % 5) == 4});
            chk($sformatf("cont_starve_%0d", i), {31'd0, starve_o}, {31'd0, (i % 5) == 4});
            if ((i % 5) == 4) exp_q.push_back({1'b1, 16'h2222});
            else              exp_q.push_back({1'b0, 16'h1111});
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ram[k] = 16'h0;
        ram[8'h10] = 16'hBEEF;
        ram[8'h01] = 16'h1111;
        ram[8'h02] = 16'h2222;
        ram[8'h03] = 16'h3333;

        // Reset with both masters requesting writes: everything must stay quiet.
        rst_n = 1'b0;
        set_m0(1'b1, 1'b1, 16'h0055, 16'hAAAA);
        set_m1(1'b1, 1'b1, 16'h0066, 16'h5555);
        tick();
        tick();
        chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", {16'd0, mem_din}, 32'd0);
        chk("rst_vld", {30'd0, m1_vld, m0_vld}, 32'd0);
        chk("rst_starve", {31'd0, starve_o}, 32'd0);

        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("idle_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("idle_mem_addr", {16'd0, mem_addr}, 32'd0);

        // m0 read of 0x0010
        tick();
        set_m0(1'b1, 1'b0, 16'h0010, 16'h0);
        #1;
        chk("rd10_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("rd10_mem_addr", {16'd0, mem_addr}, 32'h10);
        chk("rd10_mem_we", {31'd0, mem_we}, 32'd0);
        exp_q.push_back({1'b0, 16'hBEEF});

        // m1 write 0x0020 <= 0x1234, then m0 reads it back
        tick();
        idle();
        set_m1(1'b1, 1'b1, 16'h0020, 16'h1234);
        #1;
        chk("wr20_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        chk("wr20_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("wr20_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr20_mem_addr", {16'd0, mem_addr}, 32'h20);
        chk("wr20_mem_din", {16'd0, mem_din}, 32'h1234);
        tick();
        idle();
        set_m0(1'b1, 1'b0, 16'h0020, 16'h0);
        #1;
        chk("rd20_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        exp_q.push_back({1'b0, 16'h1234});
        tick();
        idle();

        // Continuous contention: two full boost periods
        contend(10);
        tick();
        idle();

        // m1 denied twice then withdraws; counter must restart from zero
        for (int i = 0; i < 2; i++) begin
            tick();
            set_m0(1'b1, 1'b0, 16'h0001, 16'h0);
            set_m1(1'b1, 1'b0, 16'h0002, 16'h0);
            #1;
            chk($sformatf("drop_m0_gnt_%0d", i), {31'd0, m0_gnt}, 32'd1);
            chk($sformatf("drop_starve_%0d", i), {31'd0, starve_o}, 32'd0);
            exp_q.push_back({1'b0, 16'h1111});
        end
        tick();
        idle();
        #1;
        chk("drop_starve_idle", {31'd0, starve_o}, 32'd0);
        contend(5);
        tick();
        idle();

        // Read granted, then reset the next cycle: no vld may appear
        tick();
        set_m0(1'b1, 1'b0, 16'h0010, 16'h0);
        #1;
        chk("rstmid_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        tick();
        rst_n = 1'b0;
        idle();
        set_m1(1'b1, 1'b1, 16'h0030, 16'h7777);
        #1;
        chk("rstmid_m0_vld", {31'd0, m0_vld}, 32'd0);
        chk("rstmid_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        #1;
        chk("rstmid_vld2", {30'd0, m1_vld, m0_vld}, 32'd0);
        tick();
        rst_n = 1'b1;
        set_m1(1'b1, 1'b0, 16'h0002, 16'h0);
        #1;
        chk("post_rst_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        exp_q.push_back({1'b1, 16'h2222});

        // Alternating single-requester reads
        tick();
        idle();
        set_m0(1'b1, 1'b0, 16'h0001, 16'h0);
        #1;
        chk("alt0_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        exp_q.push_back({1'b0, 16'h1111});
        tick();
        idle();
        set_m1(1'b1, 1'b0, 16'h0002, 16'h0);
        #1;
        chk("alt1_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        exp_q.push_back({1'b1, 16'h2222});
        tick();
        idle();
        set_m0(1'b1, 1'b0, 16'h0003, 16'h0);
        #1;
        chk("alt2_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        exp_q.push_back({1'b0, 16'h3333});
        tick();
        idle();

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
